// File: rtl/mux_sched_pkg.sv
// Shared constants, state type and index-to-one-hot helper for the 5-channel
// round-robin mux scheduler (optional lock feature: MUX_SCHED_LOCK_EN).
package mux_sched_pkg;

    localparam int         N_CH     = 5;
    localparam logic [2:0] SEL_IDLE = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_CH-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [N_CH-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first asserted request after last_ptr,
// wrapping mod 5, so the previous owner ranks lowest.
module rr_pick5
    import mux_sched_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [2:0]      last_ptr,
    output logic            found,
    output logic [2:0]      win_idx
);

    logic [2:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        idx     = 3'd0;
        // Scan farthest-first so the nearest requester after last_ptr overwrites the result.
        for (int k = N_CH; k >= 1; k--) begin
            idx = 3'((int'(last_ptr) + k) % N_CH);
            if (req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux5_rr_sched.sv
// Round-robin time-slot scheduler driving the select of a 5:1 one-bit mux.
// Define MUX_SCHED_LOCK_EN to add the lock input that extends the current grant.
module mux5_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   req,
    input  logic [SLOT_W-1:0] slot_len,
`ifdef MUX_SCHED_LOCK_EN
    input  logic              lock,
`endif
    output logic [N_CH-1:0]   gnt,
    output logic [2:0]        select,
    output logic              sel_valid
);

    state_t            state_q, state_d;
    logic [2:0]        last_ptr_q, last_ptr_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic [2:0]        sel_q, sel_d;

    logic              found;
    logic [2:0]        win_idx;
    logic              owner_req;
    logic              lock_hold;
    logic              slot_end;
    logic [SLOT_W-1:0] slot_load;

    rr_pick5 u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .found    (found),
        .win_idx  (win_idx)
    );

    // last_ptr always names the current owner while a grant is active.
    assign owner_req = req[last_ptr_q];
    assign slot_load = (slot_len == '0) ? SLOT_W'(1) : slot_len;

`ifdef MUX_SCHED_LOCK_EN
    assign lock_hold = lock & owner_req;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        slot_end   = 1'b0;

        if (!en) begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = SEL_IDLE;
        end else begin
            if (state_q == GRANT) begin
                slot_end = !owner_req || ((cnt_q == SLOT_W'(1)) && !lock_hold);
                if (!slot_end) begin
                    // Saturate at 1 so a held lock keeps the slot open indefinitely.
                    cnt_d = (cnt_q > SLOT_W'(1)) ? cnt_q - SLOT_W'(1) : cnt_q;
                end
            end
            if ((state_q == IDLE) || slot_end) begin
                if (found) begin
                    state_d    = GRANT;
                    last_ptr_d = win_idx;
                    cnt_d      = slot_load;
                    gnt_d      = idx_to_onehot(win_idx);
                    sel_d      = win_idx;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    sel_d   = SEL_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_ptr_q <= 3'(N_CH - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            sel_q      <= SEL_IDLE;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
        end
    end

    assign gnt       = gnt_q;
    assign select    = sel_q;
    assign sel_valid = |gnt_q;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// Self-checking bench for mux5_rr_sched: directed scenarios plus randomized
// traffic against a slot-counting reference model (lock scenario under MUX_SCHED_LOCK_EN).
module tb_mux5_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] req;
    logic [3:0] slot_len;
    logic       lock;
    logic [4:0] gnt;
    logic [2:0] select;
    logic       sel_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: owner (-1 = idle), last winner, cycles left in the slot.
    int m_owner = -1;
    int m_last  = 4;
    int m_left  = 0;

    always #5 clk = ~clk;

    mux5_rr_sched #(.SLOT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .slot_len  (slot_len),
`ifdef MUX_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .select    (select),
        .sel_valid (sel_valid)
    );

    function automatic int m_pick(input logic [4:0] r, input int last);
        int c;
        for (int k = 1; k <= 5; k++) begin
            c = (last + k) % 5;
            if (r[c[2:0]]) return c;
        end
        return -1;
    endfunction

    function automatic logic [4:0] exp_gnt();
        return (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    endfunction

    function automatic logic [2:0] exp_sel();
        return (m_owner < 0) ? 3'd7 : 3'(m_owner);
    endfunction

    task automatic model_step();
        int   w;
        bit   fin;
        logic lk;
`ifdef MUX_SCHED_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (rst) begin
            m_owner = -1;
            m_last  = 4;
            m_left  = 0;
        end else if (!en) begin
            m_owner = -1;
        end else begin
            fin = (m_owner < 0);
            if (m_owner >= 0) begin
                if (!req[m_owner[2:0]]) fin = 1'b1;
                else if (lk) m_left = (m_left > 1) ? m_left - 1 : 1;
                else begin
                    m_left = m_left - 1;
                    fin    = (m_left == 0);
                end
            end
            if (fin) begin
                w = m_pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_left  = (slot_len == 4'd0) ? 1 : int'(slot_len);
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    // Advance one clock, update the model with the inputs sampled at that edge, settle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 5'b11111; slot_len = 4'd2; lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (gnt !== 5'd0 || select !== 3'd7 || sel_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: gnt=%b sel=%0d vld=%b, want gnt=00000 sel=7 vld=0",
                         i, gnt, select, sel_valid);
            end
        end
        rst = 1'b0;
        cycle();
        total++;
        if (gnt !== 5'b00001 || select !== 3'd0 || sel_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: gnt=%b sel=%0d vld=%b, want gnt=00001 sel=0 vld=1",
                     gnt, select, sel_valid);
        end
    endtask

    task automatic test_rotation();
        int s;
        do_reset();
        req = 5'b11111; slot_len = 4'd2; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            s = (i / 2) % 5;
            total++;
            if (select !== 3'(s) || gnt !== 5'(1 << s) || sel_valid !== 1'b1) begin
                bad++;
                $display("FAIL rotation[%0d]: gnt=%b sel=%0d vld=%b, want gnt=%b sel=%0d vld=1",
                         i, gnt, select, sel_valid, 5'(1 << s), s);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 5'b00100; slot_len = 4'd8; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            slot_len = 4'd1;
            total++;
            if (select !== 3'd2 || gnt !== 5'b00100) begin
                bad++;
                $display("FAIL early_hold[%0d]: gnt=%b sel=%0d, want gnt=00100 sel=2", i, gnt, select);
            end
        end
        req = 5'b00000;
        cycle();
        total++;
        if (gnt !== 5'd0 || select !== 3'd7 || sel_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_release: gnt=%b sel=%0d vld=%b, want gnt=00000 sel=7 vld=0",
                     gnt, select, sel_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 5'b01000; slot_len = 4'd0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            total++;
            if (select !== 3'd3 || gnt !== 5'b01000) begin
                bad++;
                $display("FAIL single[%0d]: gnt=%b sel=%0d, want gnt=01000 sel=3", i, gnt, select);
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        req = 5'b11111; slot_len = 4'd4; en = 1'b1;
        cycle();
        cycle();
        total++;
        if (select !== 3'd0) begin
            bad++;
            $display("FAIL disable_pre: sel=%0d, want 0", select);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (gnt !== 5'd0 || select !== 3'd7) begin
                bad++;
                $display("FAIL disable_idle[%0d]: gnt=%b sel=%0d, want gnt=00000 sel=7", i, gnt, select);
            end
        end
        en = 1'b1;
        cycle();
        total++;
        if (select !== 3'd1 || gnt !== 5'b00010) begin
            bad++;
            $display("FAIL disable_resume: gnt=%b sel=%0d, want gnt=00010 sel=1", gnt, select);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 5'b11111; slot_len = 4'd4; en = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        total++;
        if (select !== 3'd2) begin
            bad++;
            $display("FAIL rst_mid_pre: sel=%0d, want 2", select);
        end
        rst = 1'b1;
        cycle();
        total++;
        if (gnt !== 5'd0 || select !== 3'd7 || sel_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: gnt=%b sel=%0d vld=%b, want gnt=00000 sel=7 vld=0",
                     gnt, select, sel_valid);
        end
        rst = 1'b0;
        cycle();
        total++;
        if (select !== 3'd0 || gnt !== 5'b00001) begin
            bad++;
            $display("FAIL rst_mid_after: gnt=%b sel=%0d, want gnt=00001 sel=0", gnt, select);
        end
    endtask

`ifdef MUX_SCHED_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 5'b11111; slot_len = 4'd2; en = 1'b1; lock = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        total++;
        if (select !== 3'd1) begin
            bad++;
            $display("FAIL lock_pre: sel=%0d, want 1", select);
        end
        lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            total++;
            if (select !== 3'd1 || gnt !== 5'b00010) begin
                bad++;
                $display("FAIL lock_hold[%0d]: gnt=%b sel=%0d, want gnt=00010 sel=1", i, gnt, select);
            end
        end
        lock = 1'b0;
        cycle();
        total++;
        if (select !== 3'd2 || gnt !== 5'b00100) begin
            bad++;
            $display("FAIL lock_release: gnt=%b sel=%0d, want gnt=00100 sel=2", gnt, select);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        req = 5'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 5'($urandom);
            en       = ($urandom_range(0, 15) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            slot_len = 4'($urandom_range(0, 5));
`ifdef MUX_SCHED_LOCK_EN
            lock     = ($urandom_range(0, 3) == 0);
`endif
            cycle();
            total++;
            if (gnt !== exp_gnt() || select !== exp_sel() || sel_valid !== (exp_gnt() != 5'd0)) begin
                bad++;
                $display("FAIL random[%0d]: gnt=%b sel=%0d vld=%b, want gnt=%b sel=%0d",
                         i, gnt, select, sel_valid, exp_gnt(), exp_sel());
            end
            total++;
            if (!$onehot0(gnt) || ((select == 3'd7) != (gnt == 5'd0))) begin
                bad++;
                $display("FAIL invariant[%0d]: gnt=%b sel=%0d, want one-hot gnt and sel==7 iff idle",
                         i, gnt, select);
            end
        end
        rst  = 1'b0;
        lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_early_release();
        test_single();
        test_disable();
        test_reset_mid();
`ifdef MUX_SCHED_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
